// File: rtl/alu_div_seq.sv
// Multi-cycle 16-bit restoring divide/modulo sequencer reusing the CPU ALU (SUB only).
// Optional signed mode: define ALU_DIV_SIGNED_EN.
package alu_pkg;
  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SEL
  } alu_op_e;
endpackage

module alu
  import alu_pkg::*;
(
  input  logic    [15:0] a,
  input  logic    [15:0] b,
  input  alu_op_e        sel,
  input  logic           cond,
  output logic    [15:0] out
);
  always_comb begin
    out = '0;
    case (sel)
      ALU_ADD: out = b + a;
      ALU_SUB: out = b - a;
      ALU_AND: out = b & a;
      ALU_OR:  out = b | a;
      ALU_XOR: out = b ^ a;
      ALU_SEL: out = cond ? b : a;
      default: out = '0;
    endcase
  end
endmodule

module alu_div_seq
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        op_mod,
  input  logic        signed_op,
  input  logic [15:0] dividend,
  input  logic [15:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        div_zero
);
  typedef enum logic [2:0] {
    IDLE,
    NEG_A,
    NEG_B,
    RUN,
    FIX,
    DONE
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] dvd_q, dvd_d;
  logic [15:0] dvs_q, dvs_d;
  logic [15:0] rem_q, rem_d;
  logic [15:0] quo_q, quo_d;
  logic [3:0]  bit_q, bit_d;
  logic        mod_q, mod_d;
  logic [15:0] res_q, res_d;
  logic        dz_q, dz_d;
  logic        fix_en;

  logic [15:0] alu_a, alu_b, alu_out;
  logic [15:0] rem_sh;
  logic        borrow;

`ifdef ALU_DIV_SIGNED_EN
  logic sgn_q, sgn_d;
  logic qneg_q, qneg_d;
  logic rneg_q, rneg_d;
  logic fix_neg;
  assign fix_en  = sgn_q;
  assign fix_neg = mod_q ? rneg_q : qneg_q;
`else
  logic unused_signed_op;
  assign unused_signed_op = signed_op;
  assign fix_en = 1'b0;
`endif

  alu u_alu (
    .a    (alu_a),
    .b    (alu_b),
    .sel  (ALU_SUB),
    .cond (1'b0),
    .out  (alu_out)
  );

  assign rem_sh = {rem_q[14:0], dvd_q[bit_q]};
  // borrow of rem_sh - divisor, from the MSBs only
  assign borrow = (~rem_sh[15] & dvs_q[15]) |
                  (~(rem_sh[15] ^ dvs_q[15]) & alu_out[15]);

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign result   = res_q;
  assign div_zero = dz_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      bit_q   <= '0;
      mod_q   <= 1'b0;
      res_q   <= '0;
      dz_q    <= 1'b0;
`ifdef ALU_DIV_SIGNED_EN
      sgn_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      bit_q   <= bit_d;
      mod_q   <= mod_d;
      res_q   <= res_d;
      dz_q    <= dz_d;
`ifdef ALU_DIV_SIGNED_EN
      sgn_q   <= sgn_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            state_d = DONE;
          end else begin
`ifdef ALU_DIV_SIGNED_EN
            state_d = signed_op ? NEG_A : RUN;
`else
            state_d = RUN;
`endif
          end
        end
      end
      NEG_A:   state_d = NEG_B;
      NEG_B:   state_d = RUN;
      RUN: begin
        if (bit_q == 4'd0) state_d = fix_en ? FIX : DONE;
      end
      FIX:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    alu_a = '0;
    alu_b = '0;
    unique case (state_q)
      NEG_A: alu_a = dvd_q;
      NEG_B: alu_a = dvs_q;
      RUN: begin
        alu_a = dvs_q;
        alu_b = rem_sh;
      end
      FIX:     alu_a = mod_q ? rem_q : quo_q;
      default: alu_a = '0;
    endcase
  end

  always_comb begin
    dvd_d = dvd_q;
    dvs_d = dvs_q;
    rem_d = rem_q;
    quo_d = quo_q;
    bit_d = bit_q;
    mod_d = mod_q;
    res_d = res_q;
    dz_d  = dz_q;
`ifdef ALU_DIV_SIGNED_EN
    sgn_d  = sgn_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          dvd_d = dividend;
          dvs_d = divisor;
          mod_d = op_mod;
          rem_d = '0;
          quo_d = '0;
          bit_d = 4'hF;
`ifdef ALU_DIV_SIGNED_EN
          sgn_d = signed_op;
`endif
          if (divisor == '0) begin
            res_d = op_mod ? dividend : 16'hFFFF;
            dz_d  = 1'b1;
          end
        end
      end
`ifdef ALU_DIV_SIGNED_EN
      NEG_A: begin
        if (dvd_q[15]) dvd_d = alu_out;
        qneg_d = dvd_q[15] ^ dvs_q[15];
        rneg_d = dvd_q[15];
      end
      NEG_B: begin
        if (dvs_q[15]) dvs_d = alu_out;
      end
      FIX: begin
        res_d = fix_neg ? alu_out : alu_a;
        dz_d  = 1'b0;
      end
`endif
      RUN: begin
        rem_d        = borrow ? rem_sh : alu_out;
        quo_d[bit_q] = ~borrow;
        bit_d        = bit_q - 4'd1;
        if (bit_q == 4'd0 && !fix_en) begin
          res_d = mod_q ? rem_d : quo_d;
          dz_d  = 1'b0;
        end
      end
      default: ;
    endcase
  end
endmodule
